sr4_byte_assembler: RTL and testbench

Downstream consumer of the 4-bit shift register (SR4RE) in the serial receive path. It watches the same shift enable that drives SR4RE, captures the parallel output every 4 shifts, and pairs two nibbles into a byte, first nibble in the high half. Bytes go into a 2-entry FIFO with a valid/ready output. A sticky overflow flag and an accepted-byte counter are provided for monitoring.

---
 rtl/sr4_byte_assembler.sv | 156 +++++++++++++++
 tb/tb_sr4_byte_assembler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr4_byte_assembler.sv
// Byte assembler downstream of a 4-bit shift register. It tracks the shared shift enable,
// pairs two captured nibbles into a byte, and queues bytes in a 2-entry valid/ready FIFO.
module sr4_byte_assembler #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             CE,
  input  logic [3:0]       Q,
  input  logic             ALIGN,
  output logic [7:0]       DOUT,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF,
  output logic [CNT_W-1:0] BYTE_CNT
);

  // Nibble tracking state
  logic [1:0]       r_bit_cnt;
  logic             r_pend;
  logic             r_phase;
  logic [3:0]       r_hi;

  // FIFO: r_head is the visible head byte, r_tail the second entry
  logic [7:0]       r_head;
  logic [7:0]       r_tail;
  logic [1:0]       r_occ;

  // Monitoring
  logic             r_ovf;
  logic [CNT_W-1:0] r_byte_cnt;

  // Next-state values
  logic [1:0]       w_bit_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_phase_nxt;
  logic [3:0]       w_hi_nxt;
  logic [7:0]       w_head_nxt;
  logic [7:0]       w_tail_nxt;
  logic [1:0]       w_occ_nxt;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] w_byte_cnt_nxt;

  // Handshake / push decode
  logic             w_pop;
  logic             w_push_req;
  logic             w_push_ok;
  logic [7:0]       w_byte;

  // A pending capture that coincides with ALIGN is thrown away, so it never pushes.
  always_comb begin
    w_pop      = (r_occ != 2'd0) && READY;
    w_push_req = r_pend && r_phase && !ALIGN;
    w_push_ok  = w_push_req && ((r_occ != 2'd2) || w_pop);
    w_byte     = {r_hi, Q};
  end

  // Bit counter, capture strobe and nibble placement.
  // NOTE: every signal written here gets its default first so no latch can be inferred.
  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt;
    w_pend_nxt    = 1'b0;
    w_phase_nxt   = r_phase;
    w_hi_nxt      = r_hi;

    if (ALIGN) begin
      w_bit_cnt_nxt = CE ? 2'd1 : 2'd0;
      w_phase_nxt   = 1'b0;
    end else begin
      if (CE) begin
        w_bit_cnt_nxt = r_bit_cnt + 2'd1;
      end
      w_pend_nxt = CE && (r_bit_cnt == 2'd3);
      // Q still holds the completed nibble here; SR4RE only moves on this edge.
      if (r_pend) begin
        if (!r_phase) begin
          w_hi_nxt    = Q;
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
        end
      end
    end
  end

  // FIFO update: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    w_occ_nxt  = r_occ;

    unique case ({w_push_ok, w_pop})
      2'b10: begin
        if (r_occ == 2'd0) begin
          w_head_nxt = w_byte;
          w_occ_nxt  = 2'd1;
        end else begin
          w_tail_nxt = w_byte;
          w_occ_nxt  = 2'd2;
        end
      end
      2'b01: begin
        w_occ_nxt = r_occ - 2'd1;
        if (r_occ == 2'd2) begin
          w_head_nxt = r_tail;
        end
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          w_head_nxt = w_byte;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = w_byte;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    w_ovf_nxt      = r_ovf || (w_push_req && !w_push_ok);
    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(w_push_ok);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (R) begin
      r_bit_cnt  <= 2'd0;
      r_pend     <= 1'b0;
      r_phase    <= 1'b0;
      r_hi       <= 4'h0;
      r_head     <= 8'h00;
      r_tail     <= 8'h00;
      r_occ      <= 2'd0;
      r_ovf      <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_phase    <= w_phase_nxt;
      r_hi       <= w_hi_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_occ      <= w_occ_nxt;
      r_ovf      <= w_ovf_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  assign DOUT     = r_head;
  assign VALID    = (r_occ != 2'd0);
  assign OVF      = r_ovf;
  assign BYTE_CNT = r_byte_cnt;

endmodule

// File: tb/tb_sr4_byte_assembler.sv
// Self-checking bench for sr4_byte_assembler: emulates the upstream SR4RE and compares
// every cycle against a bit-stream / byte-queue reference model.
module tb_sr4_byte_assembler;

  logic        CLK;
  logic        R;
  logic        CE;
  logic        SLI;
  logic [3:0]  Q;
  logic        ALIGN;
  logic        READY;
  logic [7:0]  DOUT;
  logic        VALID;
  logic        OVF;
  logic [15:0] BYTE_CNT;

  // Narrow-counter instance so the wrap of BYTE_CNT is reached quickly
  logic [7:0]  dout_s;
  logic        valid_s;
  logic        ovf_s;
  logic [2:0]  byte_cnt_s;

  sr4_byte_assembler #(.CNT_W(16)) dut (
    .CLK(CLK), .R(R), .CE(CE), .Q(Q), .ALIGN(ALIGN),
    .DOUT(DOUT), .VALID(VALID), .READY(READY), .OVF(OVF), .BYTE_CNT(BYTE_CNT)
  );

  sr4_byte_assembler #(.CNT_W(3)) dut_s (
    .CLK(CLK), .R(R), .CE(CE), .Q(Q), .ALIGN(ALIGN),
    .DOUT(dout_s), .VALID(valid_s), .READY(READY), .OVF(ovf_s), .BYTE_CNT(byte_cnt_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Upstream SR4RE: shifts SLI in at Q[0] on CE
  always @(posedge CLK) begin
    if (R)       Q <= 4'h0;
    else if (CE) Q <= {Q[2:0], SLI};
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: serial bits accumulate into bytes; a finished byte is offered
  // to a 2-deep queue one edge later.
  int          m_nbits;
  logic [7:0]  m_acc;
  logic        m_pend_v;
  logic [7:0]  m_pend_b;
  logic [7:0]  m_fifo[$];
  logic        m_ovf;
  logic [15:0] m_cnt;

  logic [7:0]  rx[$];
  int          valid_cycles;

  task automatic model_step(input logic r, ce, sli, align, ready);
    if (r) begin
      m_nbits  = 0;
      m_acc    = 8'h00;
      m_pend_v = 1'b0;
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_cnt    = 16'd0;
    end else begin
      if (m_fifo.size() != 0 && ready) void'(m_fifo.pop_front());
      if (m_pend_v && !align) begin
        if (m_fifo.size() < 2) begin
          m_fifo.push_back(m_pend_b);
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_pend_v = 1'b0;
      if (align) begin
        m_nbits = 0;
        m_acc   = 8'h00;
      end
      if (ce) begin
        m_acc   = {m_acc[6:0], sli};
        m_nbits = m_nbits + 1;
        if (m_nbits == 8) begin
          m_pend_b = m_acc;
          m_pend_v = 1'b1;
          m_nbits  = 0;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs after a falling edge, step the model on the rising
  // edge, then compare outputs on the next falling edge.
  task automatic tick(input logic r, ce, sli, align, ready);
    logic exp_valid;
    R = r; CE = ce; SLI = sli; ALIGN = align; READY = ready;
    if (!r && VALID && ready) rx.push_back(DOUT);
    @(posedge CLK);
    model_step(r, ce, sli, align, ready);
    @(negedge CLK);
    exp_valid = (m_fifo.size() != 0);
    if (VALID) valid_cycles++;
    n_tests++;
    if (VALID !== exp_valid) begin
      n_fail++;
      $display("FAIL valid @%0t: got %b expected %b", $time, VALID, exp_valid);
    end
    if (exp_valid) begin
      n_tests++;
      if (DOUT !== m_fifo[0]) begin
        n_fail++;
        $display("FAIL dout @%0t: got %h expected %h", $time, DOUT, m_fifo[0]);
      end
    end
    if (r) begin
      n_tests++;
      if (DOUT !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout @%0t: got %h expected 00", $time, DOUT);
      end
    end
    n_tests++;
    if (OVF !== m_ovf) begin
      n_fail++;
      $display("FAIL ovf @%0t: got %b expected %b", $time, OVF, m_ovf);
    end
    n_tests++;
    if (BYTE_CNT !== m_cnt) begin
      n_fail++;
      $display("FAIL byte_cnt @%0t: got %0d expected %0d", $time, BYTE_CNT, m_cnt);
    end
    n_tests++;
    if (byte_cnt_s !== m_cnt[2:0]) begin
      n_fail++;
      $display("FAIL byte_cnt_wrap @%0t: got %0d expected %0d", $time, byte_cnt_s, m_cnt[2:0]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ready, input int gap);
    for (int i = 7; i >= 0; i--) begin
      tick(1'b0, 1'b1, b[i], 1'b0, ready);
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0, ready);
    end
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, ready);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    rx.delete();
    valid_cycles = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (VALID !== 1'b0 || OVF !== 1'b0 || BYTE_CNT !== 16'd0 || DOUT !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ovf=%b cnt=%0d dout=%h expected 0/0/0/00",
               VALID, OVF, BYTE_CNT, DOUT);
    end
  endtask

  task automatic test_serial_order();
    do_reset();
    send_byte(8'hA5, 1'b1, 0);
    idle(3, 1'b1);
    n_tests++;
    if (rx.size() != 1 || rx[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL serial_order: got %0d bytes first=%h expected 1 byte a5",
               rx.size(), (rx.size() != 0) ? rx[0] : 8'hxx);
    end
    n_tests++;
    if (valid_cycles != 1) begin
      n_fail++;
      $display("FAIL serial_valid_width: got %0d cycles expected 1", valid_cycles);
    end
    n_tests++;
    if (BYTE_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL serial_cnt: got %0d expected 1", BYTE_CNT);
    end
  endtask

  task automatic test_continuous_ones();
    int bad;
    do_reset();
    for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    bad = 0;
    foreach (rx[i]) if (rx[i] !== 8'hFF) bad++;
    n_tests++;
    if (rx.size() != 25 || bad != 0) begin
      n_fail++;
      $display("FAIL continuous_bytes: got %0d bytes (%0d not ff) expected 25 of ff", rx.size(), bad);
    end
    n_tests++;
    if (BYTE_CNT !== 16'd25 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL continuous_cnt: got cnt=%0d ovf=%b expected 25/0", BYTE_CNT, OVF);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    idle(2, 1'b0);
    n_tests++;
    if (OVF !== 1'b1 || BYTE_CNT !== 16'd2) begin
      n_fail++;
      $display("FAIL backpressure_ovf: got ovf=%b cnt=%0d expected 1/2", OVF, BYTE_CNT);
    end
    idle(4, 1'b1);
    n_tests++;
    if (rx.size() != 2 || rx[0] !== 8'h11 || rx[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL backpressure_drain: got %0d bytes expected 11,22", rx.size());
    end
    n_tests++;
    if (OVF !== 1'b1 || BYTE_CNT !== 16'd2) begin
      n_fail++;
      $display("FAIL backpressure_sticky: got ovf=%b cnt=%0d expected 1/2", OVF, BYTE_CNT);
    end
  endtask

  task automatic test_sparse_ce();
    do_reset();
    send_byte(8'h3C, 1'b1, 2);
    idle(3, 1'b1);
    n_tests++;
    if (rx.size() != 1 || rx[0] !== 8'h3C) begin
      n_fail++;
      $display("FAIL sparse_ce: got %0d bytes first=%h expected 1 byte 3c",
               rx.size(), (rx.size() != 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_realign();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'hC3, 1'b1, 0);
    idle(3, 1'b1);
    n_tests++;
    if (rx.size() != 1 || rx[0] !== 8'hC3 || BYTE_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL realign: got %0d bytes cnt=%0d expected only c3, cnt 1", rx.size(), BYTE_CNT);
    end
  endtask

  task automatic test_reset_midbyte();
    do_reset();
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'h6B, 1'b0, 0);
    send_byte(8'h7C, 1'b0, 0);
    idle(2, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rx.delete();
    send_byte(8'hC3, 1'b1, 0);
    idle(3, 1'b1);
    n_tests++;
    if (rx.size() != 1 || rx[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL reset_midbyte: got %0d bytes expected only c3", rx.size());
    end
    n_tests++;
    if (OVF !== 1'b0 || BYTE_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_midbyte_clear: got ovf=%b cnt=%0d expected 0/1", OVF, BYTE_CNT);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 6));
    end
  endtask

  initial begin
    R = 1'b1; CE = 1'b0; SLI = 1'b0; ALIGN = 1'b0; READY = 1'b0;
    m_nbits = 0; m_acc = 8'h00; m_pend_v = 1'b0; m_pend_b = 8'h00;
    m_ovf = 1'b0; m_cnt = 16'd0; valid_cycles = 0;
    @(negedge CLK);
    test_reset();
    test_serial_order();
    test_continuous_ones();
    test_backpressure();
    test_sparse_ce();
    test_realign();
    test_reset_midbyte();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
